if_fetch: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program-counter stage. It accepts a fetch address plus enable from the PC stage and reads the 32-bit instruction as four byte reads over the 8-bit RAM port. It presents the assembled instruction and its PC to the decode stage with a valid/ready handshake. While busy it asserts a stall back to the PC stage so the PC holds.

---
 rtl/if_fetch_if.sv | 28 ++
 rtl/if_fetch.sv | 133 +++++++++++++
 tb/tb_if_fetch.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Bus bundle between the fetch stage and its neighbours: PC stage, byte-wide RAM and decode.
// The master modport is the fetch stage's view; slave is the environment's.
interface if_fetch_if;
   logic [31:0] pc_in;
   logic        pc_ce_in;
   logic        if_stall_out;
   logic        flush_in;
   logic [31:0] mem_a_out;
   logic        mem_rd_en_out;
   logic        mem_wr_out;
   logic [7:0]  mem_din;
   logic [31:0] inst_out;
   logic [31:0] inst_pc_out;
   logic        inst_valid_out;
   logic        id_ready_in;

   modport master (
      input  pc_in, pc_ce_in, flush_in, mem_din, id_ready_in,
      output if_stall_out, mem_a_out, mem_rd_en_out, mem_wr_out,
             inst_out, inst_pc_out, inst_valid_out
   );

   modport slave (
      output pc_in, pc_ce_in, flush_in, mem_din, id_ready_in,
      input  if_stall_out, mem_a_out, mem_rd_en_out, mem_wr_out,
             inst_out, inst_pc_out, inst_valid_out
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: reads a 32-bit little-endian instruction as four byte reads
// and hands it to decode with a valid/ready handshake, stalling the PC while busy.
module if_fetch (
   input  logic          clk_in,
   input  logic          rst_in,
   if_fetch_if.master    bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_OUT
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] base_q, base_d;
   logic [31:0] inst_buf_q, inst_buf_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic        mem_rd_en_q, mem_rd_en_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;

   // Address k is issued while cnt==k; its byte arrives one cycle later, so bytes
   // are shifted in from the top during cnt 1..4 and b0 ends up in the low lane.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      base_d       = base_q;
      inst_buf_d   = inst_buf_q;
      mem_a_d      = mem_a_q;
      mem_rd_en_d  = mem_rd_en_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;

      if (bus.flush_in) begin
         state_d      = ST_IDLE;
         cnt_d        = 3'd0;
         mem_rd_en_d  = 1'b0;
         inst_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.pc_ce_in) begin
                  state_d     = ST_FETCH;
                  cnt_d       = 3'd0;
                  base_d      = bus.pc_in;
                  mem_a_d     = bus.pc_in;
                  mem_rd_en_d = 1'b1;
               end
            end

            ST_FETCH: begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q != 3'd0) begin
                  inst_buf_d = {bus.mem_din, inst_buf_q[31:8]};
               end
               if (cnt_q < 3'd3) begin
                  mem_a_d     = base_q + {29'd0, cnt_q} + 32'd1;
                  mem_rd_en_d = 1'b1;
               end else begin
                  mem_rd_en_d = 1'b0;
               end
               if (cnt_q == 3'd4) begin
                  state_d      = ST_OUT;
                  cnt_d        = 3'd0;
                  inst_d       = {bus.mem_din, inst_buf_q[31:8]};
                  inst_pc_d    = base_q;
                  inst_valid_d = 1'b1;
               end
            end

            ST_OUT: begin
               if (bus.id_ready_in) begin
                  inst_valid_d = 1'b0;
                  if (bus.pc_ce_in) begin
                     state_d     = ST_FETCH;
                     cnt_d       = 3'd0;
                     base_d      = bus.pc_in;
                     mem_a_d     = bus.pc_in;
                     mem_rd_en_d = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end

            default: begin
               state_d      = ST_IDLE;
               cnt_d        = 3'd0;
               mem_rd_en_d  = 1'b0;
               inst_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 3'd0;
         base_q       <= 32'd0;
         inst_buf_q   <= 32'd0;
         mem_a_q      <= 32'd0;
         mem_rd_en_q  <= 1'b0;
         inst_q       <= 32'd0;
         inst_pc_q    <= 32'd0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         inst_buf_q   <= inst_buf_d;
         mem_a_q      <= mem_a_d;
         mem_rd_en_q  <= mem_rd_en_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign bus.if_stall_out   = (state_q == ST_FETCH) |
                               ((state_q == ST_OUT) & ~bus.id_ready_in);
   assign bus.mem_a_out      = mem_a_q;
   assign bus.mem_rd_en_out  = mem_rd_en_q;
   assign bus.mem_wr_out     = 1'b0;
   assign bus.inst_out       = inst_q;
   assign bus.inst_pc_out    = inst_pc_q;
   assign bus.inst_valid_out = inst_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a byte RAM model answers reads one cycle late,
// and each step checks outputs against hand-computed values.
module tb_if_fetch;

   logic clk_in;
   logic rst_in;
   int   checks;
   int   errors;

   if_fetch_if bus ();

   if_fetch dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Bytes 0x10..0x13 hold a real instruction; elsewhere a simple address hash.
   function automatic logic [7:0] ramByte(input logic [31:0] a);
      case (a)
         32'h10:  return 8'h13;
         32'h11:  return 8'h05;
         32'h12:  return 8'h10;
         32'h13:  return 8'h00;
         default: return a[7:0] ^ a[15:8] ^ 8'h5A;
      endcase
   endfunction

   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         bus.mem_din <= 8'h00;
      else if (bus.mem_rd_en_out)
         bus.mem_din <= ramByte(bus.mem_a_out);
   end

   task automatic applyStimulus(input logic [31:0] pc, input logic ce,
                                input logic flush, input logic ready);
      bus.pc_in       = pc;
      bus.pc_ce_in    = ce;
      bus.flush_in    = flush;
      bus.id_ready_in = ready;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
         $error("[TB] check %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_in = 1'b0;
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      checkOutput("rst_rd_en", {31'd0, bus.mem_rd_en_out}, 32'd0);
      checkOutput("rst_wr", {31'd0, bus.mem_wr_out}, 32'd0);
      checkOutput("rst_stall", {31'd0, bus.if_stall_out}, 32'd0);
      checkOutput("rst_mem_a", bus.mem_a_out, 32'd0);
      checkOutput("rst_inst", bus.inst_out, 32'd0);
      rst_in = 1'b1;
      tick();

      $display("[TB] basic fetch at 0x10 with backpressure");
      applyStimulus(32'h10, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("fetch_a0", bus.mem_a_out, 32'h10);
      checkOutput("fetch_rd0", {31'd0, bus.mem_rd_en_out}, 32'd1);
      checkOutput("fetch_stall", {31'd0, bus.if_stall_out}, 32'd1);
      applyStimulus(32'h10, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("fetch_a1", bus.mem_a_out, 32'h11);
      tick();
      checkOutput("fetch_a2", bus.mem_a_out, 32'h12);
      tick();
      checkOutput("fetch_a3", bus.mem_a_out, 32'h13);
      checkOutput("fetch_rd3", {31'd0, bus.mem_rd_en_out}, 32'd1);
      tick();
      checkOutput("fetch_rd4", {31'd0, bus.mem_rd_en_out}, 32'd0);
      checkOutput("fetch_valid4", {31'd0, bus.inst_valid_out}, 32'd0);
      tick();
      checkOutput("fetch_valid5", {31'd0, bus.inst_valid_out}, 32'd1);
      checkOutput("fetch_inst", bus.inst_out, 32'h00100513);
      checkOutput("fetch_pc", bus.inst_pc_out, 32'h10);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("bp_valid", {31'd0, bus.inst_valid_out}, 32'd1);
         checkOutput("bp_inst", bus.inst_out, 32'h00100513);
         checkOutput("bp_pc", bus.inst_pc_out, 32'h10);
         checkOutput("bp_stall", {31'd0, bus.if_stall_out}, 32'd1);
      end
      applyStimulus(32'h10, 1'b0, 1'b0, 1'b1);
      checkOutput("hs_stall", {31'd0, bus.if_stall_out}, 32'd0);
      tick();
      checkOutput("hs_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      checkOutput("hs_idle_stall", {31'd0, bus.if_stall_out}, 32'd0);

      $display("[TB] reset in the middle of a fetch");
      applyStimulus(32'h20, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(32'h20, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      rst_in = 1'b0;
      #1;
      checkOutput("mrst_rd_en", {31'd0, bus.mem_rd_en_out}, 32'd0);
      checkOutput("mrst_mem_a", bus.mem_a_out, 32'd0);
      checkOutput("mrst_stall", {31'd0, bus.if_stall_out}, 32'd0);
      checkOutput("mrst_inst", bus.inst_out, 32'd0);
      checkOutput("mrst_pc", bus.inst_pc_out, 32'd0);
      applyStimulus(32'h0, 1'b1, 1'b0, 1'b0);
      rst_in = 1'b1;
      tick();
      checkOutput("post_rst_a0", bus.mem_a_out, 32'h0);
      checkOutput("post_rst_rd", {31'd0, bus.mem_rd_en_out}, 32'd1);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("post_rst_valid", {31'd0, bus.inst_valid_out}, 32'd1);
      checkOutput("post_rst_inst", bus.inst_out, 32'h59585B5A);
      checkOutput("post_rst_pc", bus.inst_pc_out, 32'h0);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
      tick();

      $display("[TB] flush during fetch then refetch at 0x100");
      applyStimulus(32'h40, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(32'h40, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      applyStimulus(32'h200, 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("flush_rd_en", {31'd0, bus.mem_rd_en_out}, 32'd0);
      checkOutput("flush_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      checkOutput("flush_stall", {31'd0, bus.if_stall_out}, 32'd0);
      applyStimulus(32'h100, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("refetch_a0", bus.mem_a_out, 32'h100);
      applyStimulus(32'h100, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("refetch_valid4", {31'd0, bus.inst_valid_out}, 32'd0);
      tick();
      checkOutput("refetch_valid", {31'd0, bus.inst_valid_out}, 32'd1);
      checkOutput("refetch_pc", bus.inst_pc_out, 32'h100);
      checkOutput("refetch_inst", bus.inst_out, 32'h58595A5B);

      $display("[TB] back-to-back fetch at 0x14");
      applyStimulus(32'h14, 1'b1, 1'b0, 1'b1);
      checkOutput("b2b_stall_hs", {31'd0, bus.if_stall_out}, 32'd0);
      tick();
      checkOutput("b2b_a0", bus.mem_a_out, 32'h14);
      checkOutput("b2b_rd", {31'd0, bus.mem_rd_en_out}, 32'd1);
      checkOutput("b2b_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      checkOutput("b2b_stall", {31'd0, bus.if_stall_out}, 32'd1);
      applyStimulus(32'h14, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("b2b_inst", bus.inst_out, 32'h4D4C4F4E);
      checkOutput("b2b_pc", bus.inst_pc_out, 32'h14);

      $display("[TB] address wrap-around at 0xFFFFFFFE");
      applyStimulus(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("wrap_a0", bus.mem_a_out, 32'hFFFF_FFFE);
      applyStimulus(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("wrap_a1", bus.mem_a_out, 32'hFFFF_FFFF);
      tick();
      checkOutput("wrap_a2", bus.mem_a_out, 32'h0000_0000);
      tick();
      checkOutput("wrap_a3", bus.mem_a_out, 32'h0000_0001);
      tick();
      tick();
      checkOutput("wrap_valid", {31'd0, bus.inst_valid_out}, 32'd1);
      checkOutput("wrap_inst", bus.inst_out, 32'h5B5A5A5B);
      checkOutput("wrap_pc", bus.inst_pc_out, 32'hFFFF_FFFE);
      tick();
      checkOutput("wrap_hs_valid", {31'd0, bus.inst_valid_out}, 32'd0);

      $display("[TB] flush together with handshake in output state");
      applyStimulus(32'h10, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(32'h10, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("fo_valid_pre", {31'd0, bus.inst_valid_out}, 32'd1);
      applyStimulus(32'h14, 1'b1, 1'b1, 1'b1);
      tick();
      checkOutput("fo_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      checkOutput("fo_rd_en", {31'd0, bus.mem_rd_en_out}, 32'd0);
      checkOutput("fo_stall", {31'd0, bus.if_stall_out}, 32'd0);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
      tick();

      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
